bf16_lane_feeder: RTL and testbench



---
 rtl/bf16_lane_feeder.sv | 171 +++++++++++++++++
 tb/tb_bf16_lane_feeder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf16_lane_feeder.sv
// bf16_lane_feeder: packs a serial stream of bf16 operand pairs (a,b) into
// N-lane vectors for the MAC array. A pack register collects lanes while an
// output register presents the previous vector, so a full-rate stream keeps
// flowing whenever the consumer accepts. Each vector carries cntl1 (0 = load,
// 1 = accumulate) and out_last, both captured when the vector completes.
// Operand bits pass through untouched; unfilled lanes are padded with +0.0.
module bf16_lane_feeder #(
    parameter int N = 2
) (
    input  logic              clk1,
    input  logic              rst1,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_a,
    input  logic [15:0]       in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [16*N-1:0]   a1,
    output logic [16*N-1:0]   b1,
    output logic              cntl1,
    output logic              out_last
);

    localparam int FW = (N > 1) ? $clog2(N) : 1;
    localparam logic [FW-1:0] FILL_MAX = FW'(N - 1);

    // HELD means a completed vector waits in the pack register for the output slot.
    typedef enum logic {
        PACK_FILLING = 1'b0,
        PACK_HELD    = 1'b1
    } pack_state_t;

    pack_state_t      pack_state_r, pack_state_s;
    logic [FW-1:0]    fill_r, fill_s;
    logic [16*N-1:0]  pack_a_r, pack_a_s;
    logic [16*N-1:0]  pack_b_r, pack_b_s;
    logic             pack_cntl_r, pack_cntl_s;
    logic             pack_last_r, pack_last_s;
    logic             first_r, first_s;

    logic             out_valid_s;
    logic [16*N-1:0]  a1_s, b1_s;
    logic             cntl1_s, out_last_s;

    logic             in_fire_s, out_fire_s, out_free_s, complete_s;
    logic [16*N-1:0]  vec_a_s, vec_b_s;

    // in_ready is a pure decode of the pack state, never of in_valid.
    assign in_ready   = (pack_state_r == PACK_FILLING);
    assign in_fire_s  = in_valid && in_ready;
    assign out_fire_s = out_valid && out_ready;
    assign out_free_s = !out_valid || out_ready;
    assign complete_s = in_fire_s && ((fill_r == FILL_MAX) || in_last);

    // Candidate vector: earlier lanes from the pack register, the incoming pair
    // at lane[fill], and +0.0 in every lane above it.
    always_comb begin
        vec_a_s = '0;
        vec_b_s = '0;
        for (int k = 0; k < N; k++) begin
            if (k < int'(fill_r)) begin
                vec_a_s[16*k +: 16] = pack_a_r[16*k +: 16];
                vec_b_s[16*k +: 16] = pack_b_r[16*k +: 16];
            end else if (k == int'(fill_r)) begin
                vec_a_s[16*k +: 16] = in_a;
                vec_b_s[16*k +: 16] = in_b;
            end else begin
                vec_a_s[16*k +: 16] = 16'h0000;
                vec_b_s[16*k +: 16] = 16'h0000;
            end
        end
    end

    // Next-state logic for the pack register, the first flag and the output slot.
    always_comb begin
        pack_state_s = pack_state_r;
        fill_s       = fill_r;
        pack_a_s     = pack_a_r;
        pack_b_s     = pack_b_r;
        pack_cntl_s  = pack_cntl_r;
        pack_last_s  = pack_last_r;
        first_s      = first_r;
        a1_s         = a1;
        b1_s         = b1;
        cntl1_s      = cntl1;
        out_last_s   = out_last;

        if (out_fire_s) begin
            out_valid_s = 1'b0;
        end else begin
            out_valid_s = out_valid;
        end

        case (pack_state_r)
            PACK_FILLING: begin
                if (complete_s) begin
                    fill_s  = '0;
                    first_s = in_last;
                    if (out_free_s) begin
                        // Output slot is empty or draining this cycle: no bubble.
                        out_valid_s = 1'b1;
                        a1_s        = vec_a_s;
                        b1_s        = vec_b_s;
                        cntl1_s     = !first_r;
                        out_last_s  = in_last;
                    end else begin
                        pack_state_s = PACK_HELD;
                        pack_a_s     = vec_a_s;
                        pack_b_s     = vec_b_s;
                        pack_cntl_s  = !first_r;
                        pack_last_s  = in_last;
                    end
                end else if (in_fire_s) begin
                    fill_s   = fill_r + FW'(1);
                    pack_a_s = vec_a_s;
                    pack_b_s = vec_b_s;
                end else begin
                    fill_s = fill_r;
                end
            end
            PACK_HELD: begin
                if (out_fire_s) begin
                    pack_state_s = PACK_FILLING;
                    out_valid_s  = 1'b1;
                    a1_s         = pack_a_r;
                    b1_s         = pack_b_r;
                    cntl1_s      = pack_cntl_r;
                    out_last_s   = pack_last_r;
                end else begin
                    pack_state_s = PACK_HELD;
                end
            end
            default: begin
                pack_state_s = PACK_FILLING;
            end
        endcase
    end

    // State and output registers; reset discards partial and held vectors.
    always_ff @(posedge clk1) begin
        if (rst1) begin
            pack_state_r <= PACK_FILLING;
            fill_r       <= '0;
            pack_a_r     <= '0;
            pack_b_r     <= '0;
            pack_cntl_r  <= 1'b0;
            pack_last_r  <= 1'b0;
            first_r      <= 1'b1;
            out_valid    <= 1'b0;
            a1           <= '0;
            b1           <= '0;
            cntl1        <= 1'b0;
            out_last     <= 1'b0;
        end else begin
            pack_state_r <= pack_state_s;
            fill_r       <= fill_s;
            pack_a_r     <= pack_a_s;
            pack_b_r     <= pack_b_s;
            pack_cntl_r  <= pack_cntl_s;
            pack_last_r  <= pack_last_s;
            first_r      <= first_s;
            out_valid    <= out_valid_s;
            a1           <= a1_s;
            b1           <= b1_s;
            cntl1        <= cntl1_s;
            out_last     <= out_last_s;
        end
    end

endmodule

// File: tb/tb_bf16_lane_feeder.sv
// Self-checking bench for bf16_lane_feeder: an N=2 and an N=4 instance, each
// scored against a queue-based model of the packing rules. Directed steps
// follow the test plan, then a randomized handshake phase runs on both.
module tb_bf16_lane_feeder;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cntl;
        logic        last;
    } vec_t;

    logic clk = 1'b0;
    logic rst1;

    logic        in_valid2, in_ready2, in_last2, out_valid2, out_ready2, cntl1_2, out_last2;
    logic [15:0] in_a2, in_b2;
    logic [31:0] a1_2, b1_2;

    logic        in_valid4, in_ready4, in_last4, out_valid4, out_ready4, cntl1_4, out_last4;
    logic [15:0] in_a4, in_b4;
    logic [63:0] a1_4, b1_4;

    int nvec = 0;
    int nmis = 0;

    vec_t        exp2[$];
    vec_t        exp4[$];
    logic [63:0] pa2, pb2, pa4, pb4;
    int          pn2, pn4, vi2, vi4;

    always #5 clk = ~clk;

    bf16_lane_feeder #(.N(2)) dut2 (
        .clk1(clk), .rst1(rst1),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_a(in_a2), .in_b(in_b2), .in_last(in_last2),
        .out_valid(out_valid2), .out_ready(out_ready2), .a1(a1_2), .b1(b1_2),
        .cntl1(cntl1_2), .out_last(out_last2)
    );

    bf16_lane_feeder #(.N(4)) dut4 (
        .clk1(clk), .rst1(rst1),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_a(in_a4), .in_b(in_b4), .in_last(in_last4),
        .out_valid(out_valid4), .out_ready(out_ready4), .a1(a1_4), .b1(b1_4),
        .cntl1(cntl1_4), .out_last(out_last4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nmis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Offer one pair to the N=2 instance and hold it until accepted (bounded).
    task automatic send2(input logic [15:0] a, input logic [15:0] b, input logic l);
        int k;
        in_valid2 = 1'b1;
        in_a2 = a;
        in_b2 = b;
        in_last2 = l;
        k = 0;
        @(negedge clk);
        while (!in_ready2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("send2 accept timeout", 64'(in_ready2), 64'(1));
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        in_last2 = 1'b0;
    endtask

    // Reference model + scoreboard for the N=2 instance.
    always @(negedge clk) begin
        vec_t v;
        if (rst1) begin
            exp2.delete();
            pa2 = '0; pb2 = '0; pn2 = 0; vi2 = 0;
        end else begin
            if (out_valid2) begin
                if (exp2.size() == 0) begin
                    chk("dut2 unexpected out_valid", 64'(out_valid2), 64'(0));
                end else begin
                    chk("dut2 a1", 64'(a1_2), exp2[0].a);
                    chk("dut2 b1", 64'(b1_2), exp2[0].b);
                    chk("dut2 cntl1/out_last", 64'({cntl1_2, out_last2}),
                        64'({exp2[0].cntl, exp2[0].last}));
                    if (out_ready2) void'(exp2.pop_front());
                end
            end
            if (in_valid2 && in_ready2) begin
                pa2[16*pn2 +: 16] = in_a2;
                pb2[16*pn2 +: 16] = in_b2;
                pn2++;
                if (pn2 == 2 || in_last2) begin
                    v.a = pa2; v.b = pb2; v.cntl = (vi2 != 0); v.last = in_last2;
                    exp2.push_back(v);
                    vi2 = in_last2 ? 0 : vi2 + 1;
                    pa2 = '0; pb2 = '0; pn2 = 0;
                end
            end
        end
    end

    // Reference model + scoreboard for the N=4 instance.
    always @(negedge clk) begin
        vec_t v;
        if (rst1) begin
            exp4.delete();
            pa4 = '0; pb4 = '0; pn4 = 0; vi4 = 0;
        end else begin
            if (out_valid4) begin
                if (exp4.size() == 0) begin
                    chk("dut4 unexpected out_valid", 64'(out_valid4), 64'(0));
                end else begin
                    chk("dut4 a1", a1_4, exp4[0].a);
                    chk("dut4 b1", b1_4, exp4[0].b);
                    chk("dut4 cntl1/out_last", 64'({cntl1_4, out_last4}),
                        64'({exp4[0].cntl, exp4[0].last}));
                    if (out_ready4) void'(exp4.pop_front());
                end
            end
            if (in_valid4 && in_ready4) begin
                pa4[16*pn4 +: 16] = in_a4;
                pb4[16*pn4 +: 16] = in_b4;
                pn4++;
                if (pn4 == 4 || in_last4) begin
                    v.a = pa4; v.b = pb4; v.cntl = (vi4 != 0); v.last = in_last4;
                    exp4.push_back(v);
                    vi4 = in_last4 ? 0 : vi4 + 1;
                    pa4 = '0; pb4 = '0; pn4 = 0;
                end
            end
        end
    end

    initial begin
        rst1 = 1'b1;
        in_valid2 = 1'b0; in_a2 = 16'h0; in_b2 = 16'h0; in_last2 = 1'b0; out_ready2 = 1'b0;
        in_valid4 = 1'b0; in_a4 = 16'h0; in_b4 = 16'h0; in_last4 = 1'b0; out_ready4 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst1 = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset out_valid2", 64'(out_valid2), 64'(0));
        chk("reset in_ready2", 64'(in_ready2), 64'(1));
        chk("reset a1/b1 2", {a1_2, b1_2}, 64'(0));
        chk("reset cntl1/out_last2", 64'({cntl1_2, out_last2}), 64'(0));
        chk("reset out_valid4", 64'(out_valid4), 64'(0));
        chk("reset in_ready4", 64'(in_ready4), 64'(1));
        @(posedge clk);
        #1;

        // Single-vector dot product
        out_ready2 = 1'b1;
        send2(16'h3F80, 16'h4000, 1'b0);
        send2(16'h4040, 16'h4080, 1'b1);
        @(negedge clk);
        chk("t1 out_valid", 64'(out_valid2), 64'(1));
        chk("t1 a1", 64'(a1_2), 64'(32'h40403F80));
        chk("t1 b1", 64'(b1_2), 64'(32'h40804000));
        chk("t1 cntl1/out_last", 64'({cntl1_2, out_last2}), 64'(2'b01));
        @(posedge clk);
        #1;

        // Five pairs: three vectors, third one zero-padded in lane 1
        for (int i = 0; i < 5; i++) send2(16'h1000 + 16'(i), 16'h2000 + 16'(i), i == 4);
        @(negedge clk);
        chk("t2 out_valid", 64'(out_valid2), 64'(1));
        chk("t2 lane1 pad", 64'({a1_2[31:16], b1_2[31:16]}), 64'(0));
        chk("t2 lane0 a", 64'(a1_2[15:0]), 64'(16'h1004));
        chk("t2 cntl1/out_last", 64'({cntl1_2, out_last2}), 64'(2'b11));
        @(posedge clk);
        #1;

        // Back-pressure: output full plus pack held stalls the input
        out_ready2 = 1'b0;
        for (int i = 0; i < 4; i++) send2(16'hA000 + 16'(i), 16'hB000 + 16'(i), 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid2 = 1'($urandom_range(0, 1));
            in_a2 = 16'($urandom);
            in_b2 = 16'($urandom);
            in_last2 = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("t3 in_ready held low", 64'(in_ready2), 64'(0));
            @(posedge clk);
            #1;
        end
        in_valid2 = 1'b1; in_a2 = 16'hA004; in_b2 = 16'hB004; in_last2 = 1'b0;
        out_ready2 = 1'b1;
        @(posedge clk);
        #1 out_ready2 = 1'b0;
        @(negedge clk);
        chk("t3 in_ready after drain", 64'(in_ready2), 64'(1));
        chk("t3 out_valid after drain", 64'(out_valid2), 64'(1));
        @(posedge clk);
        #1 in_valid2 = 1'b0;
        send2(16'hA005, 16'hB005, 1'b1);
        out_ready2 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("t3 drained", 64'(exp2.size()), 64'(0));

        // Continuous N=4 stream, out_ready held high
        out_ready4 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid4 = 1'b1;
            in_a4 = 16'($urandom);
            in_b4 = 16'($urandom);
            in_last4 = (i == 15);
            @(negedge clk);
            chk("t4 in_ready4", 64'(in_ready4), 64'(1));
            chk("t4 out_valid4 cadence", 64'(out_valid4), 64'(i >= 4 && i % 4 == 0));
            @(posedge clk);
            #1;
        end
        in_valid4 = 1'b0; in_last4 = 1'b0;
        @(negedge clk);
        chk("t4 final out_valid4", 64'(out_valid4), 64'(1));
        chk("t4 final out_last4", 64'(out_last4), 64'(1));
        @(posedge clk);
        #1;

        // Reset mid-vector with the output stalled
        out_ready2 = 1'b0;
        send2(16'h1111, 16'h2222, 1'b0);
        send2(16'h3333, 16'h4444, 1'b0);
        send2(16'h5555, 16'h6666, 1'b0);
        rst1 = 1'b1;
        @(posedge clk);
        #1 rst1 = 1'b0;
        @(negedge clk);
        chk("t5 out_valid after reset", 64'(out_valid2), 64'(0));
        chk("t5 in_ready after reset", 64'(in_ready2), 64'(1));
        chk("t5 a1/b1 after reset", {a1_2, b1_2}, 64'(0));
        @(posedge clk);
        #1;
        out_ready2 = 1'b1;
        send2(16'h7777, 16'h8888, 1'b0);
        send2(16'h9999, 16'hAAAA, 1'b1);
        @(negedge clk);
        chk("t5 post-reset a1", 64'(a1_2), 64'(32'h99997777));
        chk("t5 post-reset b1", 64'(b1_2), 64'(32'hAAAA8888));
        chk("t5 post-reset cntl1/out_last", 64'({cntl1_2, out_last2}), 64'(2'b01));
        @(posedge clk);
        #1;

        // Randomized handshakes on both instances
        for (int i = 0; i < 400; i++) begin
            in_valid2 = ($urandom_range(0, 9) < 7);
            in_a2 = 16'($urandom);
            in_b2 = 16'($urandom);
            in_last2 = ($urandom_range(0, 3) == 0);
            out_ready2 = 1'($urandom_range(0, 1));
            in_valid4 = ($urandom_range(0, 9) < 7);
            in_a4 = 16'($urandom);
            in_b4 = 16'($urandom);
            in_last4 = ($urandom_range(0, 5) == 0);
            out_ready4 = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid2 = 1'b0; in_last2 = 1'b0; out_ready2 = 1'b1;
        in_valid4 = 1'b0; in_last4 = 1'b0; out_ready4 = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("random drained dut2", 64'(exp2.size()), 64'(0));
        chk("random drained dut4", 64'(exp4.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
